// File: rtl/aes128_seq_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes128_seq_pkg;

    localparam int unsigned AES128_NR_DEFAULT = 10;
    localparam logic [7:0]  RCON_INIT         = 8'h01;
    localparam logic [7:0]  RCON_POLY         = 8'h1B;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_HOLD  = 3'd4
    } seq_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_rcon_gen.sv
// Round-constant register: reloaded at INIT, stepped by xtime at the end of each full round.
module aes128_rcon_gen
    import aes128_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_d;
    logic [7:0] rcon_q;

    always_comb begin
        rcon_d = rcon_q;
        if (load_i) begin
            rcon_d = RCON_INIT;
        end else if (adv_i) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes128_round_seq.sv
// Round sequencer for the iterative AES-128 datapath.
// Optional cancel input abort_i is built when AES_SEQ_ABORT_EN is defined.
module aes128_round_seq
    import aes128_seq_pkg::*;
#(
    parameter int unsigned NR = AES128_NR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    output logic       ready_o,
    output logic       key_load_o,
    output logic       round_en_o,
    output logic       final_round_o,
    output logic [3:0] round_idx_o,
    output logic [7:0] rcon_o,
    output logic       busy_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       done_o
`ifdef AES_SEQ_ABORT_EN
    ,
    input  logic       abort_i
`endif
);

    localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

    seq_state_e state_d, state_q;
    logic [3:0] cnt_d, cnt_q;
    logic       first_d, first_q;
    logic       rcon_load, rcon_adv;
    logic       abort_c;
    logic [7:0] rcon_reg;

    aes128_rcon_gen u_rcon (
        .clk    (clk),
        .rst    (rst),
        .load_i (rcon_load),
        .adv_i  (rcon_adv),
        .rcon_o (rcon_reg)
    );

`ifdef AES_SEQ_ABORT_EN
    assign abort_c = abort_i;
`else
    assign abort_c = 1'b0;
`endif

    // Next-state, counter and output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        first_d       = 1'b0;
        rcon_load     = 1'b0;
        rcon_adv      = 1'b0;
        key_load_o    = 1'b0;
        round_en_o    = 1'b0;
        final_round_o = 1'b0;
        rcon_o        = 8'h00;
        busy_o        = 1'b0;
        out_valid_o   = 1'b0;
        done_o        = 1'b0;
        ready_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_d = ST_INIT;
                    cnt_d   = 4'd0;
                end
            end
            ST_INIT: begin
                key_load_o = 1'b1;
                busy_o     = 1'b1;
                rcon_load  = 1'b1;
                cnt_d      = 4'd1;
                state_d    = ST_ROUND;
            end
            ST_ROUND: begin
                round_en_o = 1'b1;
                busy_o     = 1'b1;
                rcon_o     = rcon_reg;
                rcon_adv   = 1'b1;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == LAST_ROUND) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                round_en_o    = 1'b1;
                final_round_o = 1'b1;
                busy_o        = 1'b1;
                rcon_o        = rcon_reg;
                cnt_d         = 4'd0;
                first_d       = 1'b1;
                state_d       = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid_o = 1'b1;
                done_o      = first_q;
                ready_o     = out_ready_i;
                if (out_ready_i) begin
                    state_d = start_i ? ST_INIT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Cancel wins over start and the output handshake.
        if (abort_c && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
            first_d  = 1'b0;
            rcon_adv = 1'b0;
        end

        ready_o = ready_o & ~rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign round_idx_o = cnt_q;

endmodule

// File: tb/tb_aes128_round_seq.sv
// Scoreboard bench for aes128_round_seq against a cycle-phase reference model.
module tb_aes128_round_seq;

    localparam int NR = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       out_ready_i = 1'b0;
    logic       ready_o, key_load_o, round_en_o, final_round_o;
    logic [3:0] round_idx_o;
    logic [7:0] rcon_o;
    logic       busy_o, out_valid_o, done_o;
`ifdef AES_SEQ_ABORT_EN
    logic       abort_i = 1'b0;
`endif

    aes128_round_seq #(.NR(NR)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .ready_o       (ready_o),
        .key_load_o    (key_load_o),
        .round_en_o    (round_en_o),
        .final_round_o (final_round_o),
        .round_idx_o   (round_idx_o),
        .rcon_o        (rcon_o),
        .busy_o        (busy_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .done_o        (done_o)
`ifdef AES_SEQ_ABORT_EN
        ,
        .abort_i       (abort_i)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       kl, re, fr, chk_idx, busy, vld, done, rdy;
        logic [3:0] idx;
        logic [7:0] rcon;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: m_k = 0 when not computing, 1 = INIT, 2..NR = rounds 1..NR-1, NR+1 = final.
    int m_k = 0;
    bit m_hold = 0, m_first = 0;
    bit p_st = 0, p_ordy = 0, p_rs = 1, p_ab = 0;

    // Round constant for round r: x^(r-1) in GF(2^8), by repeated doubling.
    function automatic logic [7:0] rc(input int r);
        int v = 1;
        for (int i = 1; i < r; i++) begin
            v = v * 2;
            if (v > 255) v = v ^ 'h11B;
        end
        return 8'(v);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, want);
        end
    endtask

    task automatic model_edge();
        if (p_rs) begin
            m_k = 0; m_hold = 0; m_first = 0;
        end else if (p_ab && (m_k != 0 || m_hold)) begin
            m_k = 0; m_hold = 0; m_first = 0;
        end else if (m_k > 0) begin
            if (m_k == NR + 1) begin
                m_k = 0; m_hold = 1; m_first = 1;
            end else begin
                m_k++;
            end
        end else if (m_hold) begin
            m_first = 0;
            if (p_ordy) begin
                m_hold = 0;
                if (p_st) m_k = 1;
            end
        end else if (p_st) begin
            m_k = 1;
        end
    endtask

    // One clock cycle: advance model at the edge, drive inputs, queue the expected outputs.
    task automatic cycle(input bit st, input bit ordy, input bit rs, input bit ab);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        start_i     = st;
        out_ready_i = ordy;
        rst         = rs;
`ifdef AES_SEQ_ABORT_EN
        abort_i     = ab;
`endif
        p_st = st; p_ordy = ordy; p_rs = rs; p_ab = ab;
        if (rs) begin
            m_k = 0; m_hold = 0; m_first = 0;
        end
        e.kl      = (m_k == 1);
        e.re      = (m_k >= 2);
        e.fr      = (m_k == NR + 1);
        e.chk_idx = (m_k >= 1) || rs;
        e.idx     = (m_k >= 1) ? 4'(m_k - 1) : 4'd0;
        e.rcon    = (m_k >= 2) ? rc(m_k - 1) : 8'h00;
        e.busy    = (m_k >= 1);
        e.vld     = m_hold;
        e.done    = m_hold && m_first;
        e.rdy     = ((m_k == 0 && !m_hold) || (m_hold && ordy)) && !rs;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("key_load", 8'(key_load_o), 8'(e.kl));
            chk("round_en", 8'(round_en_o), 8'(e.re));
            chk("final_round", 8'(final_round_o), 8'(e.fr));
            if (e.chk_idx) chk("round_idx", 8'(round_idx_o), 8'(e.idx));
            chk("rcon", rcon_o, e.rcon);
            chk("busy", 8'(busy_o), 8'(e.busy));
            chk("out_valid", 8'(out_valid_o), 8'(e.vld));
            chk("done", 8'(done_o), 8'(e.done));
            chk("ready", 8'(ready_o), 8'(e.rdy));
        end
    end

    initial begin
        // Reset, then a single start and full completion.
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (NR + 1) cycle(0, 0, 0, 0);
        // Stalled consumer with start held high.
        repeat (5) cycle(1, 0, 0, 0);
        // Back-to-back handshake into a new operation.
        cycle(1, 1, 0, 0);
        repeat (NR + 1) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        // Asynchronous reset during round 5.
        cycle(1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (NR + 1) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
`ifdef AES_SEQ_ABORT_EN
        // Abort with start in round 3, then a normal start one cycle later.
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (NR + 1) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
`endif
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit ab = 1'b0;
`ifdef AES_SEQ_ABORT_EN
            ab = ($urandom_range(0, 24) == 0);
`endif
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 199) == 0, ab);
        end
        cycle(0, 1, 0, 0);
        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drain", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
